// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - FSM state encoding
//   - default bus timeout
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for the load/store unit.
// Ports:
//   funct3, we, lo  - access size/type and address bits [1:0]
//   wdata           - raw store data (rs2)
//   rdata           - raw word read from the data bus
//   illegal         - funct3 not legal for this direction
//   misaligned      - address not aligned to access size (0 when illegal)
//   wstrb, wdata_st - byte enables and lane-steered store data (wstrb 0 for loads)
//   rdata_ext       - selected and sign/zero-extended load data
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        illegal,
    output logic        misaligned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_st,
    output logic [31:0] rdata_ext
);

    logic        legal;
    logic        mis_raw;
    logic [31:0] shifted;

    always_comb begin
        legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                (!we && ((funct3 == F3_BU) || (funct3 == F3_HU)));
        illegal = !legal;
        // H and HU share funct3[1:0] = 01.
        mis_raw = ((funct3[1:0] == 2'b01) && lo[0]) ||
                  ((funct3 == F3_W) && (lo != 2'b00));
        // An illegal funct3 is reported alone.
        misaligned = mis_raw && legal;
    end

    always_comb begin
        wstrb    = 4'b0000;
        wdata_st = wdata;
        if (we) begin
            case (funct3)
                F3_B: begin
                    wstrb    = 4'b0001 << lo;
                    wdata_st = {4{wdata[7:0]}};
                end
                F3_H: begin
                    wstrb    = 4'b0011 << lo;
                    wdata_st = {2{wdata[15:0]}};
                end
                F3_W: begin
                    wstrb    = 4'b1111;
                    wdata_st = wdata;
                end
                default: begin
                    wstrb    = 4'b0000;
                    wdata_st = wdata;
                end
            endcase
        end
    end

    always_comb begin
        shifted   = rdata >> {lo, 3'b000};
        rdata_ext = 32'h0;
        case (funct3)
            F3_B:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:  rdata_ext = rdata;
            F3_BU: rdata_ext = {24'h0, shifted[7:0]};
            F3_HU: rdata_ext = {16'h0, shifted[15:0]};
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store execution next to the ALU.
// Ports:
//   clk, reset (sync, active-low)
//   req_*   - core request (valid/ready), we, funct3, addr, wdata
//   mem_*   - data bus; mem_valid held with stable addr/we/wstrb/wdata until mem_ready
//   resp_*  - one-cycle response pulse with extended load data and error flags
//   busy    - high whenever the FSM is not in IDLE
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a bus beat completes on a rising edge where mem_valid && mem_ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_err,
    output logic        busy
);

    // Last counter value before the abort; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [2:0]       cap_f3;
    logic [1:0]       cap_lo;
    logic [CNT_W-1:0] cnt;

    logic [2:0]  sel_f3;
    logic [1:0]  sel_lo;
    logic        a_illegal;
    logic        a_misaligned;
    logic [3:0]  a_wstrb;
    logic [31:0] a_wdata;
    logic [31:0] a_rdata;

    // In IDLE the aligner looks at the live request; afterwards at the captured one.
    always_comb begin
        sel_f3 = (state == IDLE) ? req_funct3    : cap_f3;
        sel_lo = (state == IDLE) ? req_addr[1:0] : cap_lo;
    end

    lsu_align u_align (
        .funct3     (sel_f3),
        .we         (req_we),
        .lo         (sel_lo),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .illegal    (a_illegal),
        .misaligned (a_misaligned),
        .wstrb      (a_wstrb),
        .wdata_st   (a_wdata),
        .rdata_ext  (a_rdata)
    );

    assign req_ready = (state == IDLE) && reset;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            mem_valid       <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= 32'h0;
            mem_wstrb       <= 4'h0;
            mem_wdata       <= 32'h0;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'h0;
            resp_misaligned <= 1'b0;
            resp_err        <= 1'b0;
            cnt             <= '0;
            cap_f3          <= 3'b000;
            cap_lo          <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_f3 <= req_funct3;
                        cap_lo <= req_addr[1:0];
                        if (a_illegal || a_misaligned) begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_err        <= a_illegal;
                            resp_misaligned <= a_misaligned;
                            resp_rdata      <= 32'h0;
                        end else begin
                            state     <= ACCESS;
                            mem_valid <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wstrb <= a_wstrb;
                            mem_wdata <= a_wdata;
                            cnt       <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        // Completion beats the timeout on the same cycle.
                        state      <= RESP;
                        mem_valid  <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= mem_we ? 32'h0 : a_rdata;
                    end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                        state      <= RESP;
                        mem_valid  <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state           <= IDLE;
                    resp_valid      <= 1'b0;
                    resp_rdata      <= 32'h0;
                    resp_misaligned <= 1'b0;
                    resp_err        <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit (TIMEOUT = 4).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Observations collected by the driver task.
    logic        obs_ready, obs_we, obs_stable, obs_busy;
    logic [31:0] obs_maddr, obs_mwdata, obs_rdata;
    logic [3:0]  obs_strb;
    logic        obs_mis, obs_err;
    int          obs_mv, obs_lat;
    logic        obs_after_valid, obs_after_busy, obs_after_ready;

    load_store_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wstrb       (mem_wstrb),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_err        (resp_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and acts as the bus: mem_ready is raised during the
    // ready_cycle-th cycle that mem_valid is seen high (0 = never).
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ready_cycle);
        obs_ready = req_ready;
        obs_mv = 0; obs_lat = 0; obs_stable = 1'b1; obs_busy = 1'b0;
        obs_maddr = 32'h0; obs_mwdata = 32'h0; obs_strb = 4'h0; obs_we = 1'b0;
        obs_rdata = 32'h0; obs_mis = 1'b0; obs_err = 1'b0;
        obs_after_valid = 1'b1; obs_after_busy = 1'b1; obs_after_ready = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_wdata = $urandom;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (resp_valid) begin
                obs_lat = cyc; obs_rdata = resp_rdata;
                obs_mis = resp_misaligned; obs_err = resp_err;
                break;
            end
            if (mem_valid) begin
                obs_mv++;
                obs_busy = busy;
                if (obs_mv == 1) begin
                    obs_maddr = mem_addr; obs_mwdata = mem_wdata;
                    obs_strb = mem_wstrb; obs_we = mem_we;
                end else if (mem_addr !== obs_maddr || mem_wdata !== obs_mwdata ||
                             mem_wstrb !== obs_strb || mem_we !== obs_we) begin
                    obs_stable = 1'b0;
                end
            end
            mem_ready = (ready_cycle != 0) && (obs_mv == ready_cycle) && mem_valid;
            mem_rdata = mem_ready ? rdata : $urandom;
            tick();
        end
        mem_ready = 1'b0;
        if (obs_lat != 0) begin
            tick();
            obs_after_valid = resp_valid;
            obs_after_busy  = busy;
            obs_after_ready = req_ready;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        checks++; if ({mem_valid, mem_we, resp_valid, resp_misaligned, resp_err, busy} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 000000", {mem_valid, mem_we, resp_valid, resp_misaligned, resp_err, busy}); end
        checks++; if ({mem_addr, mem_wdata, mem_wstrb, resp_rdata} !== 100'h0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h exp 0", mem_addr, mem_wdata, mem_wstrb, resp_rdata); end
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_store_word();
        run_req(1'b1, 3'b010, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 2);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL sw_req_ready got %b exp 1", obs_ready); end
        checks++; if (obs_maddr !== 32'h1000_0008) begin errors++; $display("FAIL sw_addr got %h exp 10000008", obs_maddr); end
        checks++; if (obs_strb !== 4'b1111) begin errors++; $display("FAIL sw_wstrb got %b exp 1111", obs_strb); end
        checks++; if (obs_mwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", obs_mwdata); end
        checks++; if (obs_we !== 1'b1 || obs_busy !== 1'b1) begin errors++; $display("FAIL sw_we_busy got %b%b exp 11", obs_we, obs_busy); end
        checks++; if (obs_mv != 2 || !obs_stable) begin errors++; $display("FAIL sw_valid_cycles got %0d stable %b exp 2 stable 1", obs_mv, obs_stable); end
        checks++; if (obs_lat != 3) begin errors++; $display("FAIL sw_latency got %0d exp 3", obs_lat); end
        checks++; if (obs_rdata !== 32'h0 || obs_err !== 1'b0 || obs_mis !== 1'b0) begin
            errors++; $display("FAIL sw_resp got %h %b %b exp 0 0 0", obs_rdata, obs_err, obs_mis); end
        checks++; if (obs_after_valid !== 1'b0 || obs_after_busy !== 1'b0 || obs_after_ready !== 1'b1) begin
            errors++; $display("FAIL sw_pulse got v%b b%b r%b exp v0 b0 r1", obs_after_valid, obs_after_busy, obs_after_ready); end
    endtask

    task automatic test_store_byte_half();
        run_req(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0, 1);
        checks++; if (obs_maddr !== 32'h10) begin errors++; $display("FAIL sb_addr got %h exp 00000010", obs_maddr); end
        checks++; if (obs_strb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb got %b exp 1000", obs_strb); end
        checks++; if (obs_mwdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", obs_mwdata); end
        checks++; if (obs_lat != 2) begin errors++; $display("FAIL sb_latency got %0d exp 2", obs_lat); end
        run_req(1'b1, 3'b001, 32'h0000_0012, 32'h0000_1234, 32'h0, 1);
        checks++; if (obs_strb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got %b exp 1100", obs_strb); end
        checks++; if (obs_mwdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata got %h exp 12341234", obs_mwdata); end
        checks++; if (obs_maddr !== 32'h10) begin errors++; $display("FAIL sh_addr got %h exp 00000010", obs_maddr); end
    endtask

    task automatic test_loads();
        run_req(1'b0, 3'b000, 32'h21, 32'h0, 32'h0000_8000, 1);
        checks++; if (obs_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", obs_rdata); end
        checks++; if (obs_strb !== 4'b0000 || obs_we !== 1'b0 || obs_maddr !== 32'h20) begin
            errors++; $display("FAIL lb_bus got strb %b we %b addr %h exp 0000 0 00000020", obs_strb, obs_we, obs_maddr); end
        run_req(1'b0, 3'b100, 32'h21, 32'h0, 32'h0000_8000, 3);
        checks++; if (obs_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", obs_rdata); end
        checks++; if (obs_lat != 4) begin errors++; $display("FAIL lbu_latency got %0d exp 4", obs_lat); end
        run_req(1'b0, 3'b001, 32'h22, 32'h0, 32'h8001_0000, 1);
        checks++; if (obs_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_rdata got %h exp ffff8001", obs_rdata); end
        run_req(1'b0, 3'b101, 32'h22, 32'h0, 32'h8001_0000, 1);
        checks++; if (obs_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_rdata got %h exp 00008001", obs_rdata); end
        run_req(1'b0, 3'b010, 32'h44, 32'h0, 32'h8765_4321, 2);
        checks++; if (obs_rdata !== 32'h8765_4321) begin errors++; $display("FAIL lw_rdata got %h exp 87654321", obs_rdata); end
    endtask

    task automatic test_errors();
        run_req(1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1);
        checks++; if (obs_mv != 0 || obs_lat != 1) begin errors++; $display("FAIL lw_mis_timing got mv %0d lat %0d exp 0 1", obs_mv, obs_lat); end
        checks++; if (obs_mis !== 1'b1 || obs_err !== 1'b0) begin errors++; $display("FAIL lw_mis_flags got mis %b err %b exp 1 0", obs_mis, obs_err); end
        run_req(1'b0, 3'b011, 32'h8, 32'h0, 32'h0, 1);
        checks++; if (obs_err !== 1'b1 || obs_mis !== 1'b0 || obs_mv != 0 || obs_lat != 1) begin
            errors++; $display("FAIL f3_011 got err %b mis %b mv %0d lat %0d exp 1 0 0 1", obs_err, obs_mis, obs_mv, obs_lat); end
        run_req(1'b1, 3'b100, 32'h8, 32'h55, 32'h0, 1);
        checks++; if (obs_err !== 1'b1 || obs_mv != 0) begin errors++; $display("FAIL sb_f3_100 got err %b mv %0d exp 1 0", obs_err, obs_mv); end
        run_req(1'b1, 3'b101, 32'h1, 32'h55, 32'h0, 1);
        checks++; if (obs_err !== 1'b1 || obs_mis !== 1'b0) begin errors++; $display("FAIL err_priority got err %b mis %b exp 1 0", obs_err, obs_mis); end
        run_req(1'b0, 3'b101, 32'h3, 32'h0, 32'h0, 1);
        checks++; if (obs_mis !== 1'b1 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
            errors++; $display("FAIL lhu_mis got mis %b err %b rdata %h exp 1 0 0", obs_mis, obs_err, obs_rdata); end
    endtask

    task automatic test_timeout();
        run_req(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 0);
        checks++; if (obs_mv != 4) begin errors++; $display("FAIL to_valid_cycles got %0d exp 4", obs_mv); end
        checks++; if (obs_lat != 5 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
            errors++; $display("FAIL to_resp got lat %0d err %b rdata %h exp 5 1 0", obs_lat, obs_err, obs_rdata); end
        run_req(1'b0, 3'b010, 32'h40, 32'h0, 32'h1122_3344, 4);
        checks++; if (obs_mv != 4 || obs_lat != 5) begin errors++; $display("FAIL to_edge_timing got mv %0d lat %0d exp 4 5", obs_mv, obs_lat); end
        checks++; if (obs_err !== 1'b0 || obs_rdata !== 32'h1122_3344) begin
            errors++; $display("FAIL to_edge_resp got err %b rdata %h exp 0 11223344", obs_err, obs_rdata); end
    endtask

    task automatic test_back_to_back();
        run_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hAAAA_0001, 1);
        checks++; if (obs_lat != 2 || obs_after_ready !== 1'b1 || obs_rdata !== 32'hAAAA_0001) begin
            errors++; $display("FAIL b2b_first got lat %0d ready %b rdata %h exp 2 1 aaaa0001", obs_lat, obs_after_ready, obs_rdata); end
        run_req(1'b0, 3'b010, 32'h104, 32'h0, 32'hBBBB_0002, 1);
        checks++; if (obs_ready !== 1'b1 || obs_lat != 2 || obs_rdata !== 32'hBBBB_0002) begin
            errors++; $display("FAIL b2b_second got ready %b lat %0d rdata %h exp 1 2 bbbb0002", obs_ready, obs_lat, obs_rdata); end
    endtask

    task automatic test_stray_ready();
        int bad;
        bad = 0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid !== 1'b0 || busy !== 1'b0 || mem_valid !== 1'b0) bad++;
        end
        mem_ready = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL stray_ready got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_reset_mid_access();
        int bad;
        bad = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
        tick();
        req_valid = 1'b0;
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rst_access_entry got %b exp 1", mem_valid); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid got mv %b rv %b busy %b rdy %b exp 0 0 0 0", mem_valid, resp_valid, busy, req_ready); end
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid !== 1'b0 || mem_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_resp got %0d bad cycles exp 0", bad); end
        run_req(1'b0, 3'b010, 32'h84, 32'h0, 32'hCAFE_F00D, 1);
        checks++; if (obs_lat != 2 || obs_rdata !== 32'hCAFE_F00D || obs_err !== 1'b0) begin
            errors++; $display("FAIL rst_after_lw got lat %0d rdata %h err %b exp 2 cafef00d 0", obs_lat, obs_rdata, obs_err); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte_half();
        test_loads();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_stray_ready();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Execute-stage neighbour, directly downstream of the ALU. Consumes ALUResult as the effective address for RV32I loads and stores. Performs alignment checks, byte-lane steering and load sign/zero extension, and runs a valid/ready transaction on the data-memory bus with wait-state tolerance and a timeout. Returns one response per accepted request to the core, which stalls while busy is high.

Parameters:
TIMEOUT, 255, maximum cycles mem_valid stays high without mem_ready before abort; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT <= 2^CNT_W-1.

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset (see interface rule)
req_valid  in  1  core presents an access
req_ready  out  1  unit can accept an access
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  32  effective address (ALUResult)
req_wdata  in  32  store data (rs2)
mem_valid  out  1  bus request
mem_ready  in  1  bus completion
mem_we  out  1  bus write
mem_addr  out  32  word address, bits [1:0] = 0
mem_wstrb  out  4  byte enables; 0000 on reads
mem_wdata  out  32  lane-steered store data
mem_rdata  in  32  read data, valid when mem_valid && mem_ready
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_misaligned  out  1  misaligned-address error
resp_err  out  1  illegal funct3 or timeout
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface rule: single clock, clk. Reset is synchronous and active-low. reset is sampled only on the rising edge of clk; reset==0 forces reset state.
- Reset state:
  - state = IDLE.
  - mem_valid, mem_we, resp_valid, resp_misaligned, resp_err = 0.
  - mem_addr, mem_wdata, mem_wstrb, resp_rdata, timeout counter = 0.
  - req_ready = 0 while reset is asserted.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, the request is captured.
  - Legal and aligned -> ACCESS.
  - Otherwise -> RESP with the matching error flag set; no bus transaction is issued.
- Legal funct3 values: 000 B, 001 H, 010 W for both loads and stores; 100 BU and 101 HU for loads only. Any other value, or 1xx with req_we = 1, sets resp_err.
- Misalignment: H/HU with addr[0] = 1, or W with addr[1:0] != 0, sets resp_misaligned. When both checks fail, resp_err takes priority and resp_misaligned = 0.
- ACCESS:
  - mem_valid = 1.
  - mem_addr, mem_we, mem_wstrb and mem_wdata are registered and held stable until mem_ready.
  - On mem_ready, load data is captured and extended -> RESP.
- Store steering:
  - B: wstrb = 0001 << addr[1:0]; wdata = byte replicated x4.
  - H: wstrb = 0011 << addr[1:0]; wdata = half replicated x2.
  - W: wstrb = 1111.
- Load extract: select byte/half by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Timeout:
  - Counter clears on entry to ACCESS and increments each cycle without mem_ready.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no mem_ready: mem_valid drops next edge, -> RESP with resp_err = 1.
  - mem_ready on that same cycle wins: normal completion.
- RESP: resp_valid = 1 for exactly one cycle with its flags, then -> IDLE. resp_valid, resp_rdata and the flags are 0 outside RESP.
- Latency:
  - Request accepted at edge N; mem_valid is high from cycle N+1.
  - mem_ready at cycle N+k gives resp_valid at N+k+1.
  - Error responses have resp_valid at N+1.
  - Minimum issue interval is 3 cycles.
- mem_ready while mem_valid = 0 is ignored.
- Reset mid-ACCESS abandons the transaction; mem_valid is 0 after the reset edge; no response is generated.

Decomposition:
- Shared package (lsu_pkg): funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, default TIMEOUT.
- Combinational sub-module lsu_align: store lane steering/strobes, load extract/extend, legality and misalignment flags. The FSM, timeout counter and registers stay in the top module.

Test Plan:
- SW addr 0x1000_0008, wdata 0xDEADBEEF, mem_ready 2 cycles after mem_valid -> mem_addr 0x1000_0008, wstrb 1111, resp_valid 3 cycles after acceptance, rdata 0.
- SB addr 0x13, wdata 0x000000A5 -> mem_addr 0x10, wstrb 1000, wdata 0xA5A5A5A5. SH addr 0x12, wdata 0x1234 -> wstrb 1100, wdata 0x12341234.
- LB/LBU addr 0x21 with mem_rdata 0x0000_8000 -> rdata 0xFFFF_FF80 / 0x0000_0080. LH/LHU addr 0x22 with mem_rdata 0x8001_0000 -> 0xFFFF_8001 / 0x0000_8001.
- LW addr 0x6 -> no mem_valid, resp_misaligned 1 at N+1. funct3 011 -> resp_err 1. SB with funct3 100 -> resp_err 1.
- TIMEOUT = 4, mem_ready held 0 -> mem_valid high 4 cycles, then drops; resp_err 1. Repeat with mem_ready on the 4th cycle -> normal completion.
- Reset = 0 asserted in ACCESS cycle 2 -> mem_valid 0 after the edge, no resp_valid. After release, req_ready 1 and a new LW completes normally.
